analyzer_readback_sequencer: RTL and testbench

Parametrised successor to the capture readback FSM. Walks the captured sample region of a circular trace buffer, from start pointer to end pointer, and issues burst read requests to the memory interface over a req/ack handshake. It supports a programmable burst length with a partial final burst, credit-limited outstanding reads, abort, and a clean drain before reporting done. It sits between the sampler/trigger logic (begin/end pointers) and the memory read port feeding the upload FIFOs.

---
 rtl/analyzer_readback_if.sv | 21 ++
 rtl/analyzer_readback_sequencer.sv | 178 +++++++++++++++++
 tb/tb_analyzer_readback_sequencer.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/analyzer_readback_if.sv
`default_nettype none
// ============================================================================
// analyzer_readback_if : burst read-request bus, sequencer to memory read port
// Revision 1.0
// ============================================================================
interface analyzer_readback_if #(
   parameter int SAMPLE_NUM_WIDTH = 32,
   parameter int BURST_LEN        = 4
);
   localparam int LEN_W = $clog2(BURST_LEN + 1);

   logic                        rd_req;
   logic                        rd_ack;
   logic [SAMPLE_NUM_WIDTH-1:0] rd_sample;
   logic [LEN_W-1:0]            rd_len;
   logic                        rd_resp;

   modport master (output rd_req, rd_sample, rd_len, input rd_ack, rd_resp);
   modport slave  (input rd_req, rd_sample, rd_len, output rd_ack, rd_resp);
endinterface
`default_nettype wire

// File: rtl/analyzer_readback_sequencer.sv
`default_nettype none
// ============================================================================
// analyzer_readback_sequencer : walks the captured region of the circular trace
// buffer as credit-limited burst reads. Optional macro ANALYZER_READBACK_PERF_EN.
// Revision 1.0
// ============================================================================
module analyzer_readback_sequencer #(
   parameter int SAMPLE_NUM_WIDTH = 32,
   parameter int DEPTH            = 2**25,
   parameter int BURST_LEN        = 4,
   parameter int MAX_OUTSTANDING  = 8
) (
   input  wire                        clk,
   input  wire                        reset_n,
   input  wire                        idle,
   input  wire                        start,
   input  wire                        abort,
   input  wire                        buffer_full,
   input  wire [SAMPLE_NUM_WIDTH-1:0] sample_begin,
   input  wire [SAMPLE_NUM_WIDTH-1:0] sample_end,
   analyzer_readback_if.master        rd,
   output logic                       busy,
   output logic                       done,
   output logic                       aborted
`ifdef ANALYZER_READBACK_PERF_EN
   ,
   output logic [31:0]                stall_cycles,
   output logic [31:0]                req_count
`endif
);
   localparam int SW    = SAMPLE_NUM_WIDTH;
   localparam int WX    = SAMPLE_NUM_WIDTH + 1;
   localparam int LEN_W = $clog2(BURST_LEN + 1);
   localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

   localparam logic [WX-1:0]    c_depth   = WX'(DEPTH);
   localparam logic [WX-1:0]    c_burst   = WX'(BURST_LEN);
   localparam logic [LEN_W-1:0] c_len_max = LEN_W'(BURST_LEN);
   localparam logic [OUT_W-1:0] c_max_out = OUT_W'(MAX_OUTSTANDING);

   localparam logic [2:0] c_st_idle  = 3'd0;
   localparam logic [2:0] c_st_load  = 3'd1;
   localparam logic [2:0] c_st_issue = 3'd2;
   localparam logic [2:0] c_st_drain = 3'd3;
   localparam logic [2:0] c_st_done  = 3'd4;

   logic [2:0]       r_state, w_state_nxt;
   logic [SW-1:0]    r_begin, r_end, r_cur;
   logic             r_full, r_aborted;
   logic [WX-1:0]    r_remaining;
   logic [OUT_W-1:0] r_outstanding;

   logic             w_start, w_credit, w_req, w_accept, w_resp_ok, w_last;
   logic [LEN_W-1:0] w_len;
   logic [WX-1:0]    w_load_rem, w_cur_sum;
   logic [SW-1:0]    w_cur_next;

   assign w_start   = start & idle;
   assign w_credit  = (r_outstanding < c_max_out);
   assign w_len     = (r_remaining >= c_burst) ? c_len_max : LEN_W'(r_remaining);
   assign w_last    = (r_remaining == WX'(w_len));
   assign w_accept  = w_req & rd.rd_ack;
   assign w_resp_ok = rd.rd_resp & (r_outstanding != '0);
   assign w_cur_sum = {1'b0, r_cur} + WX'(w_len);
   assign w_cur_next = (w_cur_sum >= c_depth) ? SW'(w_cur_sum - c_depth) : SW'(w_cur_sum);

   // Region length modulo DEPTH, evaluated one bit wider so end+DEPTH cannot overflow
   always_comb begin
      w_load_rem = '0;
      if (r_begin == r_end)
         w_load_rem = r_full ? c_depth : '0;
      else if (r_end > r_begin)
         w_load_rem = {1'b0, r_end} - {1'b0, r_begin};
      else
         w_load_rem = {1'b0, r_end} + c_depth - {1'b0, r_begin};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= c_st_idle;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_st_idle:  if (w_start) w_state_nxt = c_st_load;
         c_st_load:  begin
            if (abort)                   w_state_nxt = c_st_drain;
            else if (w_load_rem != '0)   w_state_nxt = c_st_issue;
            else                         w_state_nxt = c_st_done;
         end
         c_st_issue: if (abort || (w_accept && w_last)) w_state_nxt = c_st_drain;
         c_st_drain: if (r_outstanding == '0) w_state_nxt = c_st_done;
         c_st_done:  if (w_start) w_state_nxt = c_st_load;
         default:    w_state_nxt = c_st_idle;
      endcase
   end

   // abort gates the request combinationally so an ack in that cycle is never taken
   always_comb begin
      w_req        = 1'b0;
      rd.rd_sample = '0;
      rd.rd_len    = '0;
      if (r_state == c_st_issue) begin
         w_req        = w_credit & ~abort;
         rd.rd_sample = r_cur;
         rd.rd_len    = w_len;
      end
      rd.rd_req = w_req;
      busy      = (r_state != c_st_idle) && (r_state != c_st_done);
      done      = (r_state == c_st_done);
      aborted   = r_aborted;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_begin       <= '0;
         r_end         <= '0;
         r_full        <= 1'b0;
         r_cur         <= '0;
         r_remaining   <= '0;
         r_outstanding <= '0;
         r_aborted     <= 1'b0;
      end else begin
         if (((r_state == c_st_idle) || (r_state == c_st_done)) && w_start) begin
            r_begin   <= sample_begin;
            r_end     <= sample_end;
            r_full    <= buffer_full;
            r_aborted <= 1'b0;
         end
         if (r_state == c_st_load) begin
            r_cur       <= r_begin;
            r_remaining <= w_load_rem;
         end
         if (w_accept) begin
            r_cur       <= w_cur_next;
            r_remaining <= r_remaining - WX'(w_len);
         end
         if (((r_state == c_st_load) || (r_state == c_st_issue)) && abort)
            r_aborted <= 1'b1;
         case ({w_accept, w_resp_ok})
            2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

`ifdef ANALYZER_READBACK_PERF_EN
   logic [31:0] r_stall_cycles, r_req_count;
   logic        w_stall, w_perf_clr;

   assign w_stall    = (r_state == c_st_issue) && (w_req ? ~rd.rd_ack : ~w_credit);
   assign w_perf_clr = ((r_state == c_st_idle) || (r_state == c_st_done)) && w_start;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_stall_cycles <= '0;
         r_req_count    <= '0;
      end else if (w_perf_clr) begin
         r_stall_cycles <= '0;
         r_req_count    <= '0;
      end else begin
         if (w_stall && (r_stall_cycles != '1))
            r_stall_cycles <= r_stall_cycles + 32'd1;
         if (w_accept && (r_req_count != '1))
            r_req_count <= r_req_count + 32'd1;
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign req_count    = r_req_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_analyzer_readback_sequencer.sv
`default_nettype none
// Directed bench for analyzer_readback_sequencer: every accepted request is
// popped from a scoreboard filled by a reference walk of the buffer region.
module tb_analyzer_readback_sequencer;
   localparam int SW = 32;
   typedef struct { logic [SW-1:0] s; int unsigned l; } req_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset_n = 1'b1, idle = 1'b1, abort = 1'b0, full = 1'b0;
   logic          start_a = 1'b0, start_b = 1'b0;
   logic [SW-1:0] s_begin = '0, s_end = '0;
   logic          busy_a, done_a, aborted_a, busy_b, done_b, aborted_b;
   logic          auto_a = 1'b1, man_a = 1'b0;
   logic          acc_a = 1'b0, acc_b = 1'b0;
   logic [1:0]    line_a = '0, line_b = '0;
   int            tests = 0, fails = 0, nacc_a = 0, nacc_b = 0;
   req_t          q_a[$], q_b[$];
`ifdef ANALYZER_READBACK_PERF_EN
   logic [31:0]   stall_a, reqc_a, stall_b, reqc_b;
`endif

   analyzer_readback_if #(.SAMPLE_NUM_WIDTH(SW), .BURST_LEN(4)) bus_a ();
   analyzer_readback_if #(.SAMPLE_NUM_WIDTH(SW), .BURST_LEN(3)) bus_b ();

   analyzer_readback_sequencer #(
      .SAMPLE_NUM_WIDTH(SW), .DEPTH(64), .BURST_LEN(4), .MAX_OUTSTANDING(2)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .idle(idle), .start(start_a), .abort(abort),
      .buffer_full(full), .sample_begin(s_begin), .sample_end(s_end), .rd(bus_a),
      .busy(busy_a), .done(done_a), .aborted(aborted_a)
`ifdef ANALYZER_READBACK_PERF_EN
      , .stall_cycles(stall_a), .req_count(reqc_a)
`endif
   );

   analyzer_readback_sequencer #(
      .SAMPLE_NUM_WIDTH(SW), .DEPTH(50), .BURST_LEN(3), .MAX_OUTSTANDING(2)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .idle(idle), .start(start_b), .abort(abort),
      .buffer_full(full), .sample_begin(s_begin), .sample_end(s_end), .rd(bus_b),
      .busy(busy_b), .done(done_b), .aborted(aborted_b)
`ifdef ANALYZER_READBACK_PERF_EN
      , .stall_cycles(stall_b), .req_count(reqc_b)
`endif
   );

   // Memory model: a response two cycles after each accept, or manual pulses
   assign bus_a.rd_resp = auto_a ? line_a[1] : man_a;
   assign bus_b.rd_resp = line_b[1];
   assign bus_b.rd_ack  = 1'b1;

   always @(posedge clk) begin
      #1;
      line_a = {line_a[0], acc_a};
      line_b = {line_b[0], acc_b};
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_req(input bit b, input logic [SW-1:0] s, input int unsigned l);
      req_t r;
      int   sz;
      sz = b ? q_b.size() : q_a.size();
      chk(b ? "req_b_expected" : "req_a_expected", 64'(sz != 0), 64'd1);
      if (sz != 0) begin
         if (b) r = q_b.pop_front();
         else   r = q_a.pop_front();
         chk(b ? "req_b_sample" : "req_a_sample", s, r.s);
         chk(b ? "req_b_len" : "req_a_len", l, r.l);
      end
   endtask

   always @(negedge clk) begin
      acc_a = (bus_a.rd_req === 1'b1) && (bus_a.rd_ack === 1'b1);
      acc_b = (bus_b.rd_req === 1'b1) && (bus_b.rd_ack === 1'b1);
      if (acc_a) begin nacc_a++; check_req(1'b0, bus_a.rd_sample, 32'(bus_a.rd_len)); end
      if (acc_b) begin nacc_b++; check_req(1'b1, bus_b.rd_sample, 32'(bus_b.rd_len)); end
   end

   task automatic model(input bit b, input int depth, input int burst,
                        input int bg, input int en, input bit f);
      int   rem, cur, l;
      req_t r;
      rem = (en >= bg) ? en - bg : en + depth - bg;
      if (bg == en) rem = f ? depth : 0;
      cur = bg;
      while (rem > 0) begin
         l   = (rem < burst) ? rem : burst;
         r.s = SW'(cur);
         r.l = l;
         if (b) q_b.push_back(r);
         else   q_a.push_back(r);
         cur = cur + l;
         if (cur >= depth) cur = cur - depth;
         rem = rem - l;
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic kick(input bit b, input int bg, input int en, input bit f);
      s_begin = SW'(bg);
      s_end   = SW'(en);
      full    = f;
      if (b) begin model(1'b1, 50, 3, bg, en, f); start_b = 1'b1; end
      else   begin model(1'b0, 64, 4, bg, en, f); start_a = 1'b1; end
      cyc(1);
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic wait_done(input bit b, input int budget);
      int n = 0;
      while (((b ? done_b : done_a) !== 1'b1) && (n < budget)) begin
         cyc(1);
         n++;
      end
      chk(b ? "done_b_wait" : "done_a_wait", 64'(b ? done_b : done_a), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int base;
      bus_a.rd_ack = 1'b1;
      reset_n = 1'b0;
      cyc(3);
      chk("reset_outputs", {bus_a.rd_req, bus_a.rd_sample, bus_a.rd_len, busy_a, done_a, aborted_a}, '0);
      reset_n = 1'b1;
      cyc(2);

      idle = 1'b0; s_begin = 10; s_end = 20; start_a = 1'b1;
      cyc(1);
      start_a = 1'b0;
      cyc(2);
      chk("start_not_idle", {busy_a, done_a}, 2'b00);
      idle = 1'b1;

      base = nacc_a;
      kick(1'b0, 10, 20, 1'b0);
      chk("busy_load", busy_a, 1'b1);
      wait_done(1'b0, 100);
      chk("lin_drained", line_a, 2'b00);
      chk("lin_nreq", nacc_a - base, 3);
      chk("lin_aborted", aborted_a, 1'b0);
      chk("lin_q_empty", q_a.size(), 0);
`ifdef ANALYZER_READBACK_PERF_EN
      chk("lin_req_count", reqc_a, 32'd3);
`endif
      cyc(3);
      chk("done_hold", done_a, 1'b1);

      base = nacc_a;
      kick(1'b0, 60, 6, 1'b0);
      wait_done(1'b0, 100);
      chk("wrap_nreq", nacc_a - base, 3);
      chk("wrap_q_empty", q_a.size(), 0);

      base = nacc_a;
      kick(1'b0, 8, 8, 1'b1);
      wait_done(1'b0, 300);
      chk("full_nreq", nacc_a - base, 16);
      chk("full_q_empty", q_a.size(), 0);

      base = nacc_a;
      kick(1'b0, 8, 8, 1'b0);
      chk("empty_done_early", done_a, 1'b0);
      cyc(1);
      chk("empty_done", done_a, 1'b1);
      chk("empty_nreq", nacc_a - base, 0);

      auto_a = 1'b0;
      base = nacc_a;
      kick(1'b0, 0, 40, 1'b0);
      cyc(8);
      chk("credit_nreq", nacc_a - base, 2);
      chk("credit_req_low", bus_a.rd_req, 1'b0);
      bus_a.rd_ack = 1'b0; man_a = 1'b1;
      cyc(1);
      man_a = 1'b0;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {bus_a.rd_req, bus_a.rd_sample, bus_a.rd_len}, {1'b1, 32'd8, 3'd4});
         cyc(1);
      end
      bus_a.rd_ack = 1'b1;
      cyc(1);
      bus_a.rd_ack = 1'b0; man_a = 1'b1;
      cyc(1);
      bus_a.rd_ack = 1'b1;
      cyc(1);
      man_a = 1'b0; bus_a.rd_ack = 1'b0;
      chk("simul_req", bus_a.rd_req, 1'b1);
      chk("simul_nreq", nacc_a - base, 4);
      bus_a.rd_ack = 1'b1;
      cyc(1);
      bus_a.rd_ack = 1'b0;
      chk("two_out_req_low", bus_a.rd_req, 1'b0);

      abort = 1'b1;
      q_a.delete();
      cyc(1);
      abort = 1'b0;
      chk("abort_flags", {aborted_a, done_a, bus_a.rd_req, busy_a}, 4'b1001);
      bus_a.rd_ack = 1'b1;
      cyc(3);
      chk("drain_wait", done_a, 1'b0);
      man_a = 1'b1;
      cyc(1);
      man_a = 1'b0;
      cyc(1);
      chk("drain_one_left", done_a, 1'b0);
      man_a = 1'b1;
      cyc(1);
      man_a = 1'b0;
      cyc(1);
      chk("abort_done", {done_a, aborted_a}, 2'b11);

      bus_a.rd_ack = 1'b0;
      base = nacc_a;
      kick(1'b0, 0, 40, 1'b0);
      chk("start_clears", {done_a, aborted_a}, 2'b00);
      cyc(1);
      abort = 1'b1; bus_a.rd_ack = 1'b1;
      #1;
      chk("abort_gate", bus_a.rd_req, 1'b0);
      q_a.delete();
      cyc(1);
      abort = 1'b0; bus_a.rd_ack = 1'b0;
      cyc(2);
      chk("abort_ack_nreq", nacc_a - base, 0);
      chk("abort_ack_done", {done_a, aborted_a}, 2'b11);

      auto_a = 1'b1;
      kick(1'b0, 20, 30, 1'b0);
      cyc(1);
      chk("issue_req", bus_a.rd_req, 1'b1);
      #1 reset_n = 1'b0;
      #1;
      chk("async_reset", {bus_a.rd_req, bus_a.rd_sample, bus_a.rd_len, busy_a, done_a, aborted_a}, '0);
      q_a.delete();
      cyc(2);
      reset_n = 1'b1;
      cyc(2);
      chk("post_reset_idle", {busy_a, done_a}, 2'b00);

      base = nacc_b;
      kick(1'b1, 48, 5, 1'b0);
      wait_done(1'b1, 100);
      chk("np2_nreq", nacc_b - base, 3);
      chk("np2_q_empty", q_b.size(), 0);
      chk("np2_aborted", aborted_b, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
